sync_updown_counter: RTL and testbench

//  Parametrised synchronous modulo-N up/down counter; successor to the fixed 4-bit T-FF up counter.

---
 rtl/counter_pkg.sv | 34 +++
 rtl/sync_tff_cell.sv | 35 +++
 rtl/sync_updown_counter.sv | 63 ++++++
 tb/tb_sync_updown_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and next-state helpers for the modulo up/down counter.
// Macro UPDOWN_COUNTER_SAT_EN switches the boundary behaviour from wrap to hold.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Out-of-range load values clamp to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] modulus);
    return (val > modulus - 32'd1) ? modulus - 32'd1 : val;
  endfunction

  function automatic logic [31:0] next_count(input logic [31:0] q,
                                             input logic        up_dn,
                                             input logic [31:0] modulus);
    logic [31:0] nxt;
    if (up_dn == CNT_UP) begin
`ifdef UPDOWN_COUNTER_SAT_EN
      nxt = (q == modulus - 32'd1) ? q : q + 32'd1;
`else
      nxt = (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
`endif
    end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
      nxt = (q == 32'd0) ? q : q - 32'd1;
`else
      nxt = (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
`endif
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_tff_cell.sv
// Single counter bit: T flip-flop with synchronous parallel load and
// synchronous active-low reset.
module sync_tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q,
  output logic qb
);

  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, terminal count and wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN for saturating instead of wrapping behaviour.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] t_vec;
  logic             at_bound;
  logic             wrap_d, wrap_q;

  always_comb begin
    at_bound = (up_dn == CNT_UP) ? (32'(q) == MODULUS - 32'd1) : (q == '0);
    tc       = en & at_bound;
    cnt_next = WIDTH'(next_count(32'(q), up_dn, MODULUS));
    ld_val   = WIDTH'(clamp_load(32'(load_val), MODULUS));
    // Each cell toggles exactly where the arithmetic next value differs from q.
    t_vec    = en ? (cnt_next ^ q) : '0;
`ifdef UPDOWN_COUNTER_SAT_EN
    wrap_d   = 1'b0;
`else
    wrap_d   = en & ~load & at_bound;
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .ld  (load),
      .d   (ld_val[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: a MODULUS=10 and a MODULUS=16 counter share stimulus; an
// independent model pushes expected results to a queue that is popped after each edge.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, wrap10, tc16, wrap16;

  typedef struct {
    logic [3:0] q10;
    logic       w10;
    logic [3:0] q16;
    logic       w16;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   m10, m16;
  logic w10, w16;
  logic exp_tc10, exp_tc16;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16)
  );

  function automatic void step_model(input logic r, input logic e, input logic u,
                                     input logic l, input int lv, input int m,
                                     inout int cur, output logic w);
    w = 1'b0;
    if (!r) begin
      cur = 0;
    end else if (l) begin
      cur = (lv > m - 1) ? m - 1 : lv;
    end else if (e) begin
      if (u) begin
        if (cur == m - 1) begin
`ifndef UPDOWN_COUNTER_SAT_EN
          cur = 0;
          w   = 1'b1;
`endif
        end else begin
          cur = cur + 1;
        end
      end else begin
        if (cur == 0) begin
`ifndef UPDOWN_COUNTER_SAT_EN
          cur = m - 1;
          w   = 1'b1;
`endif
        end else begin
          cur = cur - 1;
        end
      end
    end
  endfunction

  // Drive inputs, record the combinational tc expectation and push the post-edge result.
  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv);
    rst = r; en = e; up_dn = u; load = l; load_val = lv;
    exp_tc10 = e & (u ? (m10 == 9) : (m10 == 0));
    exp_tc16 = e & (u ? (m16 == 15) : (m16 == 0));
    step_model(r, e, u, l, int'(lv), 10, m10, w10);
    step_model(r, e, u, l, int'(lv), 16, m16, w16);
    sb.push_back('{q10: 4'(m10), w10: w10, q16: 4'(m16), w16: w16});
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q16 !== ex.q16) $display("FAIL reset_q16 got %0d exp %0d", q16, ex.q16);
      else n_pass++;
      n_total++;
      if (qb16 !== 4'hF) $display("FAIL reset_qb16 got %h exp f", qb16);
      else n_pass++;
      n_total++;
      if (wrap16 !== 1'b0 || wrap10 !== 1'b0)
        $display("FAIL reset_wrap got %b/%b exp 0/0", wrap16, wrap10);
      else n_pass++;
    end
    // tc while held in reset: only en=1 with down direction
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'(i >> 1), 1'(i), 1'b0, 4'd0);
      n_total++;
      if (tc16 !== exp_tc16 || tc10 !== exp_tc10)
        $display("FAIL reset_tc en=%0d up=%0d got %b/%b exp %b/%b", i >> 1, i & 1,
                 tc16, tc10, exp_tc16, exp_tc10);
      else n_pass++;
      clk_edge();
      ex = sb.pop_front();
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      n_total++;
      if (tc10 !== exp_tc10) $display("FAIL up_tc got %b exp %b", tc10, exp_tc10);
      else n_pass++;
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q10 !== ex.q10 || wrap10 !== ex.w10)
        $display("FAIL up_q got q=%0d w=%b exp q=%0d w=%b", q10, wrap10, ex.q10, ex.w10);
      else n_pass++;
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    clk_edge();
    ex = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      n_total++;
      if (tc10 !== exp_tc10) $display("FAIL down_tc got %b exp %b", tc10, exp_tc10);
      else n_pass++;
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q10 !== ex.q10 || wrap10 !== ex.w10)
        $display("FAIL down_q got q=%0d w=%b exp q=%0d w=%b", q10, wrap10, ex.q10, ex.w10);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    // 12 clamps to 9; repeat at q=9 counting up so load must beat the wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, (i == 2) ? 4'd5 : 4'd12);
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q10 !== ex.q10 || wrap10 !== ex.w10 || q16 !== ex.q16)
        $display("FAIL load got q10=%0d w=%b q16=%0d exp q10=%0d w=%b q16=%0d",
                 q10, wrap10, q16, ex.q10, ex.w10, ex.q16);
      else n_pass++;
    end
  endtask

  task automatic test_reset_override();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    clk_edge();
    ex = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    clk_edge();
    ex = sb.pop_front();
    n_total++;
    if (q10 !== ex.q10 || q16 !== ex.q16 || wrap10 !== 1'b0)
      $display("FAIL rst_override got q10=%0d q16=%0d w=%b exp %0d %0d 0",
               q10, q16, wrap10, ex.q10, ex.q16);
    else n_pass++;
  endtask

  task automatic test_boundary();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
    clk_edge();
    ex = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q10 !== ex.q10 || wrap10 !== ex.w10 || q16 !== ex.q16)
        $display("FAIL boundary got q10=%0d w=%b q16=%0d exp %0d %b %0d",
                 q10, wrap10, q16, ex.q10, ex.w10, ex.q16);
      else n_pass++;
    end
    // full-range counter must match plain binary wrap 15 -> 0
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
    clk_edge();
    ex = sb.pop_front();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    n_total++;
    if (tc16 !== exp_tc16) $display("FAIL pow2_tc got %b exp %b", tc16, exp_tc16);
    else n_pass++;
    clk_edge();
    ex = sb.pop_front();
    n_total++;
    if (q16 !== ex.q16 || wrap16 !== ex.w16)
      $display("FAIL pow2_wrap got q=%0d w=%b exp q=%0d w=%b", q16, wrap16, ex.q16, ex.w16);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
            4'($urandom));
      n_total++;
      if (tc10 !== exp_tc10 || tc16 !== exp_tc16)
        $display("FAIL b2b_tc got %b/%b exp %b/%b", tc10, tc16, exp_tc10, exp_tc16);
      else n_pass++;
      clk_edge();
      ex = sb.pop_front();
      n_total++;
      if (q10 !== ex.q10 || wrap10 !== ex.w10 || q16 !== ex.q16 || wrap16 !== ex.w16 ||
          qb10 !== ~ex.q10 || qb16 !== ~ex.q16)
        $display("FAIL b2b_state got q10=%0d w10=%b q16=%0d w16=%b exp %0d %b %0d %b",
                 q10, wrap10, q16, wrap16, ex.q10, ex.w10, ex.q16, ex.w16);
      else n_pass++;
    end
  endtask

  initial begin
    m10 = 0; m16 = 0;
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_reset_override();
    test_boundary();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
